// File: rtl/instr_decode_stage.sv
// Registered RV32I/RV64I decode stage. The instruction word is decoded
// before capture, and the decoded fields are stored behind a valid/ready
// handshake. A main+skid register pair keeps the stage running at full
// rate under back-pressure. A saturating counter tallies illegal encodings.
module instr_decode_stage #(
    parameter int XLEN      = 32,   // immediate width, 32 or 64
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [PC_WIDTH-1:0]  in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic [6:0]           out_opcode,
    output logic [4:0]           out_rd,
    output logic [2:0]           out_funct3,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [6:0]           out_funct7,
    output logic [2:0]           out_type,
    output logic [XLEN-1:0]      out_imm,
    output logic [CNT_WIDTH-1:0] illegal_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held
        FULL1 = 2'd1,   // main holds an entry
        FULL2 = 2'd2    // main and skid both hold entries
    } state_t;

    localparam logic [2:0] TYPE_R       = 3'd0;
    localparam logic [2:0] TYPE_I       = 3'd1;
    localparam logic [2:0] TYPE_S       = 3'd2;
    localparam logic [2:0] TYPE_B       = 3'd3;
    localparam logic [2:0] TYPE_U       = 3'd4;
    localparam logic [2:0] TYPE_J       = 3'd5;
    localparam logic [2:0] TYPE_ILLEGAL = 3'd7;

    state_t                state_reg, state_next;
    logic                  in_ready_reg;

    // Main entry drives the outputs; skid catches one entry while stalled.
    logic [31:0]           main_instr_reg, skid_instr_reg;
    logic [PC_WIDTH-1:0]   main_pc_reg, skid_pc_reg;
    logic [2:0]            main_type_reg, skid_type_reg;
    logic [XLEN-1:0]       main_imm_reg, skid_imm_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;

    logic [2:0]            dec_type;
    logic [31:0]           dec_imm32;
    logic [XLEN-1:0]       dec_imm;
    logic                  accept;
    logic                  load_main_new;
    logic                  load_skid;
    logic                  move_skid;
    logic                  cnt_inc;

    assign accept = in_valid && in_ready_reg;

    // Classify the incoming word and assemble its 32-bit immediate.
    always_comb begin
        dec_type  = TYPE_ILLEGAL;
        dec_imm32 = 32'd0;
        case (in_instr[6:0])
            7'b0110011: dec_type = TYPE_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                dec_type  = TYPE_I;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_type  = TYPE_S;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_type  = TYPE_B;
                dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_type  = TYPE_U;
                dec_imm32 = {in_instr[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_type  = TYPE_J;
                dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
            default: begin
                dec_type  = TYPE_ILLEGAL;
                dec_imm32 = 32'd0;
            end
        endcase
        // Bit 31 of every format's immediate is instr[31] (or 0), so a
        // signed widening gives the required sign extension to XLEN.
        dec_imm = XLEN'($signed(dec_imm32));
    end

    // Buffer state machine: next state and register load selects.
    always_comb begin
        state_next    = state_reg;
        load_main_new = 1'b0;
        load_skid     = 1'b0;
        move_skid     = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    load_main_new = 1'b1;
                    state_next    = FULL1;
                end
            end
            FULL1: begin
                if (out_ready) begin
                    if (accept) begin
                        load_main_new = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = FULL2;
                end
            end
            FULL2: begin
                if (out_ready) begin
                    move_skid  = 1'b1;
                    state_next = FULL1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush overrides every transfer; the held data is simply abandoned.
        if (flush) begin
            state_next    = EMPTY;
            load_main_new = 1'b0;
            load_skid     = 1'b0;
            move_skid     = 1'b0;
        end
    end

    // Illegal entries count only if they are really kept (not flushed).
    assign cnt_inc = accept && !flush && (dec_type == TYPE_ILLEGAL) && (cnt_reg != '1);

    // State, ready flag and counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= EMPTY;
            in_ready_reg <= 1'b1;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != FULL2);
            if (cnt_inc) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Main entry: loaded from the decoder or from the skid register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_instr_reg <= '0;
            main_pc_reg    <= '0;
            main_type_reg  <= '0;
            main_imm_reg   <= '0;
        end else if (load_main_new) begin
            main_instr_reg <= in_instr;
            main_pc_reg    <= in_pc;
            main_type_reg  <= dec_type;
            main_imm_reg   <= dec_imm;
        end else if (move_skid) begin
            main_instr_reg <= skid_instr_reg;
            main_pc_reg    <= skid_pc_reg;
            main_type_reg  <= skid_type_reg;
            main_imm_reg   <= skid_imm_reg;
        end
    end

    // Skid entry: catches the word accepted while main is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_instr_reg <= '0;
            skid_pc_reg    <= '0;
            skid_type_reg  <= '0;
            skid_imm_reg   <= '0;
        end else if (load_skid) begin
            skid_instr_reg <= in_instr;
            skid_pc_reg    <= in_pc;
            skid_type_reg  <= dec_type;
            skid_imm_reg   <= dec_imm;
        end
    end

    assign in_ready      = in_ready_reg;
    assign out_valid     = (state_reg != EMPTY);
    assign out_pc        = main_pc_reg;
    assign out_opcode    = main_instr_reg[6:0];
    assign out_rd        = main_instr_reg[11:7];
    assign out_funct3    = main_instr_reg[14:12];
    assign out_rs1       = main_instr_reg[19:15];
    assign out_rs2       = main_instr_reg[24:20];
    assign out_funct7    = main_instr_reg[31:25];
    assign out_type      = main_type_reg;
    assign out_imm       = main_imm_reg;
    assign illegal_count = cnt_reg;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage. Three instances share stimulus:
// the default build, an XLEN=64 build and a CNT_WIDTH=2 build.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3, out_type;
    logic [31:0] out_imm;
    logic [7:0]  illegal_count;

    logic        w_in_ready, w_out_valid;
    logic [31:0] w_out_pc;
    logic [6:0]  w_out_opcode, w_out_funct7;
    logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;
    logic [2:0]  w_out_funct3, w_out_type;
    logic [63:0] w_out_imm;
    logic [7:0]  w_illegal_count;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_pc;
    logic [6:0]  s_out_opcode, s_out_funct7;
    logic [4:0]  s_out_rd, s_out_rs1, s_out_rs2;
    logic [2:0]  s_out_funct3, s_out_type;
    logic [31:0] s_out_imm;
    logic [1:0]  s_illegal_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(32), .PC_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
        .out_type(out_type), .out_imm(out_imm), .illegal_count(illegal_count)
    );

    instr_decode_stage #(.XLEN(64), .PC_WIDTH(32), .CNT_WIDTH(8)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_out_pc),
        .out_opcode(w_out_opcode), .out_rd(w_out_rd), .out_funct3(w_out_funct3),
        .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_funct7(w_out_funct7),
        .out_type(w_out_type), .out_imm(w_out_imm), .illegal_count(w_illegal_count)
    );

    instr_decode_stage #(.XLEN(32), .PC_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc),
        .out_opcode(s_out_opcode), .out_rd(s_out_rd), .out_funct3(s_out_funct3),
        .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_funct7(s_out_funct7),
        .out_type(s_out_type), .out_imm(s_out_imm), .illegal_count(s_illegal_count)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; out_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        checks++;
        if (out_pc !== 32'd0 || out_imm !== 32'd0 || out_type !== 3'd0 || out_opcode !== 7'd0) begin
            failures++;
            $display("FAIL reset_data: pc=%h imm=%h type=%0d opc=%h required all 0", out_pc, out_imm, out_type, out_opcode);
        end
        checks++;
        if (illegal_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d required 0", illegal_count);
        end
        $display("test_reset done");
    endtask

    task automatic test_itype;
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h100;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_type !== 3'd1 || out_opcode !== 7'h13 || out_rd !== 5'd1 ||
            out_rs1 !== 5'd2 || out_funct3 !== 3'd0 || out_imm !== 32'hFFFFFFFF || out_pc !== 32'h100) begin
            failures++;
            $display("FAIL itype: v=%b type=%0d opc=%h rd=%0d rs1=%0d f3=%0d imm=%h pc=%h required 1/1/13/1/2/0/ffffffff/100",
                     out_valid, out_type, out_opcode, out_rd, out_rs1, out_funct3, out_imm, out_pc);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL itype_drain: out_valid=%b required 0", out_valid);
        end
        $display("test_itype addi x1,x2,-1 checked");
    endtask

    // S, B, U words back-to-back with out_ready high: one entry per cycle.
    task automatic test_formats;
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00512423; in_pc = 32'h200;
        step();
        in_instr = 32'hFE000EE3; in_pc = 32'h204;
        checks++;
        if (out_valid !== 1'b1 || out_type !== 3'd2 || out_rs1 !== 5'd2 || out_rs2 !== 5'd5 ||
            out_funct3 !== 3'd2 || out_imm !== 32'h00000008 || out_pc !== 32'h200) begin
            failures++;
            $display("FAIL stype: v=%b type=%0d rs1=%0d rs2=%0d f3=%0d imm=%h pc=%h required 1/2/2/5/2/00000008/200",
                     out_valid, out_type, out_rs1, out_rs2, out_funct3, out_imm, out_pc);
        end
        step();
        in_instr = 32'h123451B7; in_pc = 32'h208;
        checks++;
        if (out_valid !== 1'b1 || out_type !== 3'd3 || out_imm !== 32'hFFFFFFFC || out_pc !== 32'h204) begin
            failures++;
            $display("FAIL btype: v=%b type=%0d imm=%h pc=%h required 1/3/fffffffc/204",
                     out_valid, out_type, out_imm, out_pc);
        end
        step();
        in_instr = 32'h800002B7; in_pc = 32'h20C;
        checks++;
        if (out_valid !== 1'b1 || out_type !== 3'd4 || out_rd !== 5'd3 || out_imm !== 32'h12345000 || out_pc !== 32'h208) begin
            failures++;
            $display("FAIL utype: v=%b type=%0d rd=%0d imm=%h pc=%h required 1/4/3/12345000/208",
                     out_valid, out_type, out_rd, out_imm, out_pc);
        end
        step();
        in_instr = 32'h0000006F; in_pc = 32'h210;
        checks++;
        if (w_out_imm !== 64'hFFFFFFFF80000000 || w_out_type !== 3'd4 || out_imm !== 32'h80000000) begin
            failures++;
            $display("FAIL lui_xlen64: imm64=%h type=%0d imm32=%h required ffffffff80000000/4/80000000",
                     w_out_imm, w_out_type, out_imm);
        end
        step();
        in_valid = 1'b0;
        // jal x0,0 : J-type with zero offset
        checks++;
        if (out_type !== 3'd5 || out_imm !== 32'd0 || out_pc !== 32'h210) begin
            failures++;
            $display("FAIL jtype: type=%0d imm=%h pc=%h required 5/00000000/210", out_type, out_imm, out_pc);
        end
        step();
        $display("test_formats S/B/U/J and XLEN=64 lui checked");
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [4];
        logic [31:0] pcs [4];
        int sent;
        int got;
        logic hs_in;
        logic hs_out;
        words[0] = 32'h00100093; words[1] = 32'h00200093;
        words[2] = 32'h00300093; words[3] = 32'h00400093;
        pcs[0] = 32'h300; pcs[1] = 32'h304; pcs[2] = 32'h308; pcs[3] = 32'h30C;
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = (cyc >= 4);
            if (sent < 4) begin
                in_valid = 1'b1; in_instr = words[sent]; in_pc = pcs[sent];
            end else begin
                in_valid = 1'b0;
            end
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== pcs[0] || out_imm !== 32'd1) begin
                    failures++;
                    $display("FAIL backpressure_hold cyc%0d: in_ready=%b v=%b pc=%h imm=%h required 0/1/%h/00000001",
                             cyc, in_ready, out_valid, out_pc, out_imm, pcs[0]);
                end
            end
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                checks++;
                if (out_pc !== pcs[got] || out_imm !== 32'(got + 1)) begin
                    failures++;
                    $display("FAIL order[%0d]: pc=%h imm=%h required %h/%h", got, out_pc, out_imm, pcs[got], got + 1);
                end
                $display("back_to_back pop %0d pc=%h", got, out_pc);
                got++;
            end
            step();
            if (hs_in) sent++;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 4 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_count: popped=%0d out_valid=%b required 4/0", got, out_valid);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_illegal;
        apply_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h400;
        step();
        checks++;
        if (out_type !== 3'd7 || out_imm !== 32'd0 || illegal_count !== 8'd1) begin
            failures++;
            $display("FAIL illegal_first: type=%0d imm=%h cnt=%0d required 7/0/1", out_type, out_imm, illegal_count);
        end
        step();
        checks++;
        if (illegal_count !== 8'd2 || s_illegal_count !== 2'd2) begin
            failures++;
            $display("FAIL illegal_two: cnt=%0d cnt2=%0d required 2/2", illegal_count, s_illegal_count);
        end
        // 0x10 has instr[1:0]=00; then three more plain zero words
        in_instr = 32'h00000010;
        step();
        in_instr = 32'h00000000;
        step();
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (illegal_count !== 8'd5 || s_illegal_count !== 2'd3) begin
            failures++;
            $display("FAIL illegal_saturate: cnt=%0d cnt2=%0d required 5/3", illegal_count, s_illegal_count);
        end
        $display("test_illegal counts=%0d sat=%0d", illegal_count, s_illegal_count);
    endtask

    task automatic test_flush;
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h500;
        step();
        in_pc = 32'h504;
        step();
        in_instr = 32'h00000000; in_pc = 32'h508; flush = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_pre_full2: in_ready=%b required 0", in_ready);
        end
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_full2: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || illegal_count !== 8'd0) begin
            failures++;
            $display("FAIL flush_no_skid: out_valid=%b cnt=%0d required 0/0", out_valid, illegal_count);
        end
        // an illegal word accepted in the flush cycle is dropped and not counted
        in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h50C; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || illegal_count !== 8'd0) begin
            failures++;
            $display("FAIL flush_accept: out_valid=%b cnt=%0d required 0/0", out_valid, illegal_count);
        end
        $display("test_flush done");
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h600;
        step();
        in_instr = 32'hFFF10093; in_pc = 32'h604;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || illegal_count !== 8'd1) begin
            failures++;
            $display("FAIL reset_mid_pre: v=%b in_ready=%b cnt=%0d required 1/0/1", out_valid, in_ready, illegal_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== 8'd0 || out_pc !== 32'd0 || out_type !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid: v=%b in_ready=%b cnt=%0d pc=%h type=%0d required 0/1/0/0/0",
                     out_valid, in_ready, illegal_count, out_pc, out_type);
        end
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after: out_valid=%b required 0", out_valid);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_itype();
        test_formats();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, parametrised RV32I/RV64I decode stage sitting between instruction fetch and register read. Each accepted instruction word is split into its standard fields, classified by format, and given a sign-extended immediate. Results come out one cycle later behind a valid/ready handshake. A two-entry skid buffer keeps full throughput under back-pressure, and a saturating counter tracks illegal encodings.

## Interface
- XLEN, 32: immediate width; legal values 32 or 64.
- PC_WIDTH, 32: width of the passthrough PC tag.
- CNT_WIDTH, 8: width of the illegal-instruction counter.

- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  instruction word.
- in_pc  in  PC_WIDTH  PC of in_instr.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_WIDTH  PC of the entry.
- out_opcode  out  7  instr[6:0].
- out_rd  out  5  instr[11:7].
- out_funct3  out  3  instr[14:12].
- out_rs1  out  5  instr[19:15].
- out_rs2  out  5  instr[24:20].
- out_funct7  out  7  instr[31:25].
- out_type  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
- out_imm  out  XLEN  sign-extended immediate.
- illegal_count  out  CNT_WIDTH  number of illegal entries accepted.

## Operation
- **Classification by opcode.**
  - R: 0110011.
  - I: 0010011, 0000011, 1100111, 0001111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode is illegal (type 7), including any word with instr[1:0] != 2'b11.
- **Immediates.** Every immediate is sign-extended from instr[31] to XLEN.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and illegal: 0.
- **Field outputs.** All field outputs are raw slices regardless of type.
- **Buffer.** Two registers: main (drives the outputs) and skid.
  - Decode logic runs on in_instr before capture; decoded results are what get stored.
  - Accept when in_valid && in_ready.
  - in_ready = !skid_valid.
- **Buffer state machine:**
  - EMPTY: accept -> FULL1.
  - FULL1, out_ready=1: with accept, main reloads and the state stays FULL1; without accept -> EMPTY.
  - FULL1, out_ready=0: with accept, the new entry goes to skid -> FULL2.
  - FULL2 (in_ready=0), out_ready=1: skid moves to main -> FULL1.
  - FULL2, out_ready=0: hold.
- **Ordering.** Entries leave in acceptance order. The skid entry is never overtaken.
- **Illegal counter.** Increments by 1 per accepted entry with type 7. It saturates at all-ones and is not cleared by flush.
- **Flush** (has priority over everything):
  - Next cycle: out_valid=0, skid_valid=0, in_ready=1.
  - An input accepted in the flush cycle is discarded and not counted.
  - illegal_count is unchanged, apart from an increment for an illegal entry accepted in an earlier cycle.

## Timing
- **Reset values:**
  - out_valid=0, in_ready=1.
  - All data outputs 0.
  - illegal_count=0.
  - Skid empty.
- **Reset behaviour.** Reset acts immediately, asynchronously, and may occur mid-transfer; held entries are lost.
- **Latency.** 1 cycle from accept to out_valid.
- **Throughput.** 1 entry per cycle while out_ready=1.
- **in_ready.** in_ready is a register output with no combinational path from out_ready.
  - It drops the cycle after a skid fill.
  - It rises the cycle after the skid drains.
- **Output stability.** While out_valid=1 and out_ready=0, all out_* hold stable.
- **Counter timing.** illegal_count updates the cycle after the accept edge, together with out_valid.

## Test plan
- **I-type (XLEN=32).** in_instr=0xFFF10093 (addi x1,x2,-1), in_pc=0x100 -> one cycle later: out_type=1, opcode=0x13, rd=1, rs1=2, funct3=0, out_imm=0xFFFFFFFF, out_pc=0x100.
- **S, B, U formats.**
  - 0x00512423 -> type=2, rs1=2, rs2=5, funct3=2, imm=0x00000008.
  - 0xFE000EE3 -> type=3, imm=0xFFFFFFFC.
  - 0x123451B7 -> type=4, rd=3, imm=0x12345000.
- **XLEN=64.** 0x800002B7 (lui) -> imm=0xFFFFFFFF80000000.
- **Back-pressure.** Stream 4 words back-to-back with out_ready=0 -> word 1 in main, word 2 in skid, in_ready=0 from cycle 3. Then assert out_ready -> words 1–4 emerge in order with no loss or duplication.
- **Illegal and saturation.** Feed 0x00000000 twice -> type=7, imm=0, illegal_count=2. With CNT_WIDTH=2, feed 5 illegal words -> count stays at 3.
- **Flush and reset.**
  - Flush in FULL2 while a word is presented -> next cycle out_valid=0, in_ready=1, and the presented word never appears.
  - Deassert reset_n mid-stream -> outputs go to reset values immediately.
